// File: rtl/ram_pkg.sv
// Shared sizing constants for the unified instruction/data memory.
//   ADDR_WIDTH   : address bits, shared by both banks
//   DATA_WIDTH   : data-bank word width
//   INST_WIDTH   : instruction-bank word width
//   NUM_MEM_ADDR : words per bank
package ram_pkg;

  localparam int unsigned ADDR_WIDTH   = 8;
  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned INST_WIDTH   = 16;
  localparam int unsigned NUM_MEM_ADDR = 2 ** ADDR_WIDTH;

endpackage

// File: rtl/ram_bank.sv
// Single-port memory bank with a registered, write-first read port.
//   clk    : clock, all updates on rising edge
//   rst_n  : asynchronous active-low reset; clears rdata and blocks writes
//   read   : load rdata from mem[addr]
//   write  : store wdata into mem[addr]
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read data, holds when read=0
module ram_bank #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Array has no reset (contents survive reset), but writes are gated off
  // while reset is held so a reset mid-operation drops that cycle's write.
  always_ff @(posedge clk) begin
    if (rst_n && write) begin
      mem[addr] <= wdata;
    end
  end

  // Write-first: a simultaneous read returns the incoming write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (read) begin
      rdata <= write ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/ram.sv
// Unified memory block: independent instruction and data banks sharing
// clock and reset. Both banks may be accessed in the same cycle.
//   Clk            : clock
//   Rst_n          : asynchronous active-low reset (outputs to 0, writes blocked)
//   Ram_Data_Read  : data-bank read strobe
//   Ram_Data_Write : data-bank write strobe
//   Ram_Inst_Read  : instruction-bank read strobe
//   Ram_Inst_Write : instruction-bank write strobe
//   Ram_Addr       : data-bank address
//   Inst_Addr      : instruction-bank address
//   Ram_Data_In    : data-bank write data
//   Ram_Inst_In    : instruction-bank write data
//   Ram_Data_Out   : registered data-bank read data
//   Ram_Inst_Out   : registered instruction-bank read data
module ram
  import ram_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Ram_Data_Read,
  input  logic                  Ram_Data_Write,
  input  logic                  Ram_Inst_Read,
  input  logic                  Ram_Inst_Write,
  input  logic [ADDR_WIDTH-1:0] Ram_Addr,
  input  logic [ADDR_WIDTH-1:0] Inst_Addr,
  input  logic [DATA_WIDTH-1:0] Ram_Data_In,
  input  logic [INST_WIDTH-1:0] Ram_Inst_In,
  output logic [DATA_WIDTH-1:0] Ram_Data_Out,
  output logic [INST_WIDTH-1:0] Ram_Inst_Out
);

  ram_bank #(
    .WIDTH      (INST_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_inst_bank (
    .clk   (Clk),
    .rst_n (Rst_n),
    .read  (Ram_Inst_Read),
    .write (Ram_Inst_Write),
    .addr  (Inst_Addr),
    .wdata (Ram_Inst_In),
    .rdata (Ram_Inst_Out)
  );

  ram_bank #(
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_data_bank (
    .clk   (Clk),
    .rst_n (Rst_n),
    .read  (Ram_Data_Read),
    .write (Ram_Data_Write),
    .addr  (Ram_Addr),
    .wdata (Ram_Data_In),
    .rdata (Ram_Data_Out)
  );

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for the unified instruction/data memory.
module tb_ram;
  import ram_pkg::*;

  logic                  Clk = 1'b0;
  logic                  Rst_n = 1'b1;
  logic                  Ram_Data_Read = 1'b0;
  logic                  Ram_Data_Write = 1'b0;
  logic                  Ram_Inst_Read = 1'b0;
  logic                  Ram_Inst_Write = 1'b0;
  logic [ADDR_WIDTH-1:0] Ram_Addr = '0;
  logic [ADDR_WIDTH-1:0] Inst_Addr = '0;
  logic [DATA_WIDTH-1:0] Ram_Data_In = '0;
  logic [INST_WIDTH-1:0] Ram_Inst_In = '0;
  logic [DATA_WIDTH-1:0] Ram_Data_Out;
  logic [INST_WIDTH-1:0] Ram_Inst_Out;

  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;

  // Scoreboard copy of both arrays, kept up to date by every test.
  logic [DATA_WIDTH-1:0] m_data [NUM_MEM_ADDR];
  logic [INST_WIDTH-1:0] m_inst [NUM_MEM_ADDR];

  ram dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .Ram_Data_Read  (Ram_Data_Read),
    .Ram_Data_Write (Ram_Data_Write),
    .Ram_Inst_Read  (Ram_Inst_Read),
    .Ram_Inst_Write (Ram_Inst_Write),
    .Ram_Addr       (Ram_Addr),
    .Inst_Addr      (Inst_Addr),
    .Ram_Data_In    (Ram_Data_In),
    .Ram_Inst_In    (Ram_Inst_In),
    .Ram_Data_Out   (Ram_Data_Out),
    .Ram_Inst_Out   (Ram_Inst_Out)
  );

  always #5 Clk = ~Clk;

  // Apply one cycle of stimulus (called 1 time unit after a rising edge),
  // then return 1 time unit after the next rising edge.
  task automatic drive(input logic dr, input logic dw, input logic ir, input logic iw,
                       input logic [7:0] ra, input logic [7:0] ia,
                       input logic [7:0] din, input logic [15:0] iin);
    Ram_Data_Read  = dr;
    Ram_Data_Write = dw;
    Ram_Inst_Read  = ir;
    Ram_Inst_Write = iw;
    Ram_Addr       = ra;
    Inst_Addr      = ia;
    Ram_Data_In    = din;
    Ram_Inst_In    = iin;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    // Produce a real negedge on Rst_n, outputs must clear without a clock.
    #2 Rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (Ram_Data_Out !== 8'h00 || Ram_Inst_Out !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_initial: data=%h inst=%h required 00/0000", Ram_Data_Out, Ram_Inst_Out);
    end
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    drive(1, 1, 1, 1, 8'd0, 8'd0, 8'hAA, 16'hBEEF);
    m_data[0] = 8'hAA;
    m_inst[0] = 16'hBEEF;
    cmp_cnt++;
    if (Ram_Data_Out !== 8'hAA || Ram_Inst_Out !== 16'hBEEF) begin
      err_cnt++;
      $display("FAIL reset_preload: data=%h inst=%h required AA/BEEF", Ram_Data_Out, Ram_Inst_Out);
    end
    drive(0, 0, 0, 0, 8'd0, 8'd0, 8'h00, 16'h0000);
    #2 Rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (Ram_Data_Out !== 8'h00 || Ram_Inst_Out !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_async: data=%h inst=%h required 00/0000", Ram_Data_Out, Ram_Inst_Out);
    end
    // Writes presented while reset is held must be dropped.
    @(posedge Clk);
    #1;
    drive(1, 1, 1, 1, 8'd0, 8'd0, 8'h55, 16'h5555);
    cmp_cnt++;
    if (Ram_Data_Out !== 8'h00 || Ram_Inst_Out !== 16'h0000) begin
      err_cnt++;
      $display("FAIL reset_held_out: data=%h inst=%h required 00/0000", Ram_Data_Out, Ram_Inst_Out);
    end
    Rst_n = 1'b1;
    drive(1, 0, 1, 0, 8'd0, 8'd0, 8'h00, 16'h0000);
    cmp_cnt++;
    if (Ram_Data_Out !== 8'hAA || Ram_Inst_Out !== 16'hBEEF) begin
      err_cnt++;
      $display("FAIL reset_write_blocked: data=%h inst=%h required AA/BEEF", Ram_Data_Out, Ram_Inst_Out);
    end
  endtask

  task automatic test_fill();
    logic [7:0]  a;
    logic [15:0] ia;
    for (int i = 0; i < 256; i++) begin
      a  = 8'(i);
      ia = ~{8'h00, a};
      drive(1, 1, 1, 1, a, a, a, ia);
      m_data[i] = a;
      m_inst[i] = ia;
      cmp_cnt++;
      if (Ram_Data_Out !== a || Ram_Inst_Out !== ia) begin
        err_cnt++;
        $display("FAIL fill_wfirst[%0d]: data=%h inst=%h required %h/%h", i, Ram_Data_Out, Ram_Inst_Out, a, ia);
      end
    end
    for (int i = 0; i < 256; i++) begin
      a  = 8'(i);
      ia = ~{8'h00, a};
      drive(1, 0, 1, 0, a, a, 8'hFF, 16'h0000);
      cmp_cnt++;
      if (Ram_Data_Out !== a || Ram_Inst_Out !== ia) begin
        err_cnt++;
        $display("FAIL fill_reread[%0d]: data=%h inst=%h required %h/%h", i, Ram_Data_Out, Ram_Inst_Out, a, ia);
      end
    end
  endtask

  task automatic test_hold();
    drive(1, 0, 1, 0, 8'd10, 8'd10, 8'h00, 16'h0000);
    cmp_cnt++;
    if (Ram_Data_Out !== 8'h0A || Ram_Inst_Out !== 16'hFFF5) begin
      err_cnt++;
      $display("FAIL hold_setup: data=%h inst=%h required 0A/FFF5", Ram_Data_Out, Ram_Inst_Out);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 8'(20 + k), 8'(40 + k), 8'h00, 16'h0000);
      cmp_cnt++;
      if (Ram_Data_Out !== 8'h0A || Ram_Inst_Out !== 16'hFFF5) begin
        err_cnt++;
        $display("FAIL hold[%0d]: data=%h inst=%h required 0A/FFF5", k, Ram_Data_Out, Ram_Inst_Out);
      end
    end
  endtask

  task automatic test_isolation();
    drive(0, 1, 0, 0, 8'd5, 8'd5, 8'h3C, 16'h0000);
    m_data[5] = 8'h3C;
    drive(0, 0, 0, 1, 8'd5, 8'd5, 8'h00, 16'h1234);
    m_inst[5] = 16'h1234;
    drive(1, 0, 1, 0, 8'd5, 8'd5, 8'h00, 16'h0000);
    cmp_cnt++;
    if (Ram_Data_Out !== 8'h3C) begin
      err_cnt++;
      $display("FAIL isolation_data: got %h required 3C", Ram_Data_Out);
    end
    cmp_cnt++;
    if (Ram_Inst_Out !== 16'h1234) begin
      err_cnt++;
      $display("FAIL isolation_inst: got %h required 1234", Ram_Inst_Out);
    end
  endtask

  task automatic test_write_no_read();
    // Outputs currently 3C / 1234 from the isolation test.
    drive(0, 1, 0, 1, 8'd7, 8'd7, 8'hA5, 16'hC0DE);
    m_data[7] = 8'hA5;
    m_inst[7] = 16'hC0DE;
    cmp_cnt++;
    if (Ram_Data_Out !== 8'h3C || Ram_Inst_Out !== 16'h1234) begin
      err_cnt++;
      $display("FAIL wnr_hold: data=%h inst=%h required 3C/1234", Ram_Data_Out, Ram_Inst_Out);
    end
    drive(1, 0, 1, 0, 8'd7, 8'd7, 8'h00, 16'h0000);
    cmp_cnt++;
    if (Ram_Data_Out !== 8'hA5 || Ram_Inst_Out !== 16'hC0DE) begin
      err_cnt++;
      $display("FAIL wnr_read: data=%h inst=%h required A5/C0DE", Ram_Data_Out, Ram_Inst_Out);
    end
  endtask

  task automatic test_random();
    logic [DATA_WIDTH-1:0] e_data;
    logic [INST_WIDTH-1:0] e_inst;
    logic                  rst, dr, dw, ir, iw;
    logic [7:0]            ra, ia, din;
    logic [15:0]           iin;
    e_data = Ram_Data_Out;
    e_inst = Ram_Inst_Out;
    for (int n = 0; n < 1000; n++) begin
      rst = ($urandom_range(0, 19) != 0);
      dr  = 1'($urandom);
      dw  = 1'($urandom);
      ir  = 1'($urandom);
      iw  = 1'($urandom);
      ra  = 8'($urandom);
      ia  = 8'($urandom);
      din = 8'($urandom);
      iin = 16'($urandom);
      Rst_n = rst;
      drive(dr, dw, ir, iw, ra, ia, din, iin);
      if (!rst) begin
        e_data = '0;
        e_inst = '0;
      end else begin
        if (dw) m_data[ra] = din;
        if (iw) m_inst[ia] = iin;
        if (dr) e_data = m_data[ra];
        if (ir) e_inst = m_inst[ia];
      end
      cmp_cnt++;
      if (Ram_Data_Out !== e_data || Ram_Inst_Out !== e_inst) begin
        err_cnt++;
        $display("FAIL random[%0d]: data=%h inst=%h required %h/%h", n, Ram_Data_Out, Ram_Inst_Out, e_data, e_inst);
      end
    end
    Rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_isolation();
    test_write_no_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
